// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad decoder: FSM state encoding,
// key codes matching the game FSM's operator encoding, and the matrix map.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  // Operator aliases used by the game FSM
  localparam logic [3:0] KEY_ADD = KEY_A;
  localparam logic [3:0] KEY_SUB = KEY_B;
  localparam logic [3:0] KEY_DIV = KEY_C;
  localparam logic [3:0] KEY_MUL = KEY_D;

  // Physical position (row, column) to key code
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_0;
      4'b11_01: code = KEY_F;
      4'b11_10: code = KEY_E;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Key event bus from the keypad decoder to the game FSM.
// decode is only meaningful while key_valid is high.
interface keypad_if;
  logic [3:0] decode;
  logic       key_valid;
  logic       key_down;

  modport master (output decode, output key_valid, output key_down);
  modport slave  (input  decode, input  key_valid, input  key_down);
endinterface

// File: rtl/keypad_col_scanner.sv
// Column scanner: synchronizes the row lines, drives one column low at a
// time for SCAN_CYCLES each, and reports the highest-priority key seen in a
// full scan (lowest column, then lowest row) with a one-cycle scan_end.
module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       scan_end,
  output logic       hit,
  output logic [3:0] code
);

  localparam int            DW         = $clog2(SCAN_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [3:0]    col_q;
  logic          acc_hit;
  logic [3:0]    acc_code;
  logic          sample;
  logic          row_low;
  logic [1:0]    first_row;
  logic [3:0]    sample_code;

  // Two-flop synchronizer; resets to all-ones so no key is seen after reset
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Rows are sampled on the last dwell cycle so the column has settled
  assign sample  = (dwell == DWELL_LAST);
  assign row_low = ~&row_sync;

  // Dwell counter and column rotation 1110 -> 1101 -> 1011 -> 0111
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell   <= '0;
      col_idx <= 2'd0;
      col_q   <= 4'b1110;
    end else if (sample) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
      col_q   <= {col_q[2:0], col_q[3]};
    end else begin
      dwell   <= dwell + DW'(1);
    end
  end

  assign col = col_q;

  // Lowest active-low row in the current column wins
  // NOTE: default assignment first keeps always_comb free of inferred latches.
  always_comb begin
    first_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) first_row = 2'(r);
    end
  end

  assign sample_code = key_code(first_row, col_idx);

  // Per-scan accumulator: column 0 starts a fresh scan, later columns only
  // fill in if nothing was found earlier in the scan
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hit  <= 1'b0;
      acc_code <= KEY_0;
    end else if (sample) begin
      if (col_idx == 2'd0) begin
        acc_hit  <= row_low;
        acc_code <= sample_code;
      end else if (!acc_hit && row_low) begin
        acc_hit  <= 1'b1;
        acc_code <= sample_code;
      end
    end
  end

  // Scan result is complete on the column-3 sample cycle
  assign scan_end = sample && (col_idx == 2'd3);
  assign hit      = acc_hit | row_low;
  assign code     = acc_hit ? acc_code : sample_code;

endmodule

// File: rtl/keypad_decoder.sv
// Keypad decoder top: column scanner plus debounce FSM.  One key_valid
// strobe per debounced press; key_down spans strobe to confirmed release.
// Optional feature macro: KEYPAD_REPEAT_EN (autorepeat while held).
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  keypad_if.master   key_bus
);

  if (SCAN_CYCLES < 4 || DEBOUNCE_SCANS < 2 || REPEAT_SCANS < 1) begin : g_param_check
    $error("keypad_decoder: parameter out of range");
  end

  localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_SCANS);

  logic       scan_end;
  logic       hit;
  logic [3:0] code;

  state_t        state, state_n;
  logic [3:0]    cand, cand_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] rel, rel_n;
  // Held off after reset until a scan sees no key, so a key held across
  // reset must be released and pressed again
  logic          armed, armed_n;
  logic          strobe;
  logic          key_valid_q, key_valid_n;
  logic [3:0]    decode_q, decode_n;
  logic          key_down_q, key_down_n;

`ifdef KEYPAD_REPEAT_EN
  localparam int            RW       = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS);
  logic [RW-1:0] rep, rep_n;
`endif

  keypad_col_scanner #(.SCAN_CYCLES(SCAN_CYCLES)) u_scanner (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .scan_end (scan_end),
    .hit      (hit),
    .code     (code)
  );

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cand  <= KEY_0;
      cnt   <= '0;
      rel   <= '0;
      armed <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep   <= '0;
`endif
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
      rel   <= rel_n;
      armed <= armed_n;
`ifdef KEYPAD_REPEAT_EN
      rep   <= rep_n;
`endif
    end
  end

  // Next-state and counter updates, evaluated only on scan_end
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    rel_n   = rel;
    armed_n = armed;
    strobe  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_n   = rep;
`endif
    if (scan_end) begin
      if (!hit) armed_n = 1'b1;
      case (state)
        IDLE: begin
          if (hit && armed) begin
            cand_n  = code;
            cnt_n   = CW'(1);
            state_n = CONFIRM;
          end
        end
        CONFIRM: begin
          if (hit && code == cand) begin
            cnt_n = cnt + CW'(1);
            if (cnt_n == DB_LAST) begin
              strobe  = 1'b1;
              cnt_n   = '0;
              rel_n   = '0;
              state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_n   = '0;
`endif
            end
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        HELD: begin
          if (hit) begin
            rel_n = '0;
          end else begin
            rel_n = rel + CW'(1);
            if (rel_n == DB_LAST) begin
              rel_n   = '0;
              state_n = IDLE;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          if (hit && code == cand) begin
            rep_n = rep + RW'(1);
            if (rep_n == REP_LAST) begin
              strobe = 1'b1;
              rep_n  = '0;
            end
          end else begin
            rep_n = '0;
          end
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output values to register: strobe carries the candidate code
  always_comb begin
    key_valid_n = strobe;
    decode_n    = strobe ? cand : KEY_0;
    key_down_n  = (state_n == HELD);
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q <= 1'b0;
      decode_q    <= KEY_0;
      key_down_q  <= 1'b0;
    end else begin
      key_valid_q <= key_valid_n;
      decode_q    <= decode_n;
      key_down_q  <= key_down_n;
    end
  end

  assign key_bus.key_valid = key_valid_q;
  assign key_bus.decode    = decode_q;
  assign key_bus.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder with a scan-level reference model.
module tb_keypad_decoder;

  localparam int S = 4;
  localparam int D = 3;
  localparam int R = 2;
  localparam int M_IDLE = 0;
  localparam int M_CONF = 1;
  localparam int M_HELD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] keys;   // keys[r*4+c] = 1 while pressed

  keypad_if key_bus ();

  keypad_decoder #(
    .SCAN_CYCLES    (S),
    .DEBOUNCE_SCANS (D),
    .REPEAT_SCANS   (R)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row     (row),
    .col     (col),
    .key_bus (key_bus)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  logic [3:0] key_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'h0, 4'hF, 4'hE, 4'hD};

  int          checks = 0;
  int          errors = 0;
  int          t;               // index of the next clock edge since reset release
  logic [15:0] hist [$];        // keys present at each edge
  int          m_mode, m_cnt, m_rel, m_rep;
  bit          m_armed;
  logic [3:0]  m_cand;
  logic [9:0]  exp_vec;         // {col, key_valid, decode, key_down}
  logic [9:0]  obs;
  int          n_strobes = 0;
  logic [3:0]  last_code;
  int          last_strobe_t;

  // Scan result for the scan ending at edge k: column c is read at edge
  // k-(3-c)*S and sees the keys from two edges earlier (synchronizer)
  function automatic void scan_result(input int k, output bit hit, output logic [3:0] code);
    hit  = 1'b0;
    code = 4'h0;
    for (int c = 0; c < 4; c++) begin
      logic [15:0] m;
      m = hist[k - (3 - c) * S - 2];
      for (int r = 0; r < 4; r++)
        if (!hit && m[r*4+c]) begin
          hit  = 1'b1;
          code = key_tbl[r*4+c];
        end
    end
  endfunction

  function automatic void model_step(input int k);
    bit         hit;
    bit         strobe;
    logic [3:0] code;
    logic [3:0] ecol;
    strobe = 1'b0;
    if (k % S == S - 1 && (k / S) % 4 == 3) begin
      scan_result(k, hit, code);
      if (m_mode == M_IDLE) begin
        if (hit && m_armed) begin
          m_cand = code;
          m_cnt  = 1;
          m_mode = M_CONF;
        end
      end else if (m_mode == M_CONF) begin
        if (hit && code == m_cand) begin
          m_cnt++;
          if (m_cnt == D) begin
            strobe = 1'b1;
            m_mode = M_HELD;
            m_rel  = 0;
            m_rep  = 0;
          end
        end else begin
          m_cnt  = 0;
          m_mode = M_IDLE;
        end
      end else begin
        if (hit) m_rel = 0;
        else     m_rel++;
`ifdef KEYPAD_REPEAT_EN
        if (hit && code == m_cand) begin
          m_rep++;
          if (m_rep == R) begin
            strobe = 1'b1;
            m_rep  = 0;
          end
        end else begin
          m_rep = 0;
        end
`endif
        if (m_rel == D) m_mode = M_IDLE;
      end
      if (!hit) m_armed = 1'b1;
    end
    ecol    = 4'hF & ~(4'h1 << (((k + 1) / S) % 4));
    exp_vec = {ecol, strobe, strobe ? m_cand : 4'h0, m_mode == M_HELD};
  endfunction

  // Advance one clock: update the model for this edge, then sample the DUT 1 ns later
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      t       = 0;
      hist.delete();
      m_mode  = M_IDLE;
      m_cnt   = 0;
      m_rel   = 0;
      m_rep   = 0;
      m_armed = 1'b0;
      m_cand  = 4'h0;
      exp_vec = {4'b1110, 1'b0, 4'h0, 1'b0};
    end else begin
      hist.push_back(keys);
      model_step(t);
      t++;
    end
    #1;
    obs = {col, key_bus.key_valid, key_bus.decode, key_bus.key_down};
    if (key_bus.key_valid === 1'b1) begin
      n_strobes++;
      last_code     = key_bus.decode;
      last_strobe_t = t - 1;
    end
  endtask

  task automatic test_reset();
    int n0;
    keys = 16'h0;
    rst  = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (obs !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
        errors++;
        $display("FAIL reset_values got %b want %b (col|valid|decode|down)", obs, {4'b1110, 6'b0});
      end
    end
    rst = 1'b0;
    n0  = n_strobes;
    repeat (100) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL idle_scan cycle %0d got %b want %b (col|valid|decode|down)", t, obs, exp_vec);
      end
    end
    checks++;
    if (n_strobes !== n0) begin
      errors++;
      $display("FAIL idle_no_strobe got %0d strobes want 0", n_strobes - n0);
    end
  endtask

  task automatic test_single_press();
    int n0, p;
    n0   = n_strobes;
    keys = 16'h0002;   // r0/c1 = "2"
    p    = t;
    repeat (80) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL single_hold cycle %0d got %b want %b (col|valid|decode|down)", t, obs, exp_vec);
      end
    end
    checks++;
    if (n_strobes - n0 !== 1 || last_code !== 4'h2) begin
      errors++;
      $display("FAIL single_count got %0d strobes code %h want 1 code 2", n_strobes - n0, last_code);
    end
    checks++;
    if (last_strobe_t - p + 1 > 67) begin
      errors++;
      $display("FAIL single_latency got %0d cycles want <= 67", last_strobe_t - p + 1);
    end
    keys = 16'h0;
    repeat (80) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL single_release cycle %0d got %b want %b (col|valid|decode|down)", t, obs, exp_vec);
      end
    end
    checks++;
    if (key_bus.key_down !== 1'b0) begin
      errors++;
      $display("FAIL single_key_down_cleared got %b want 0", key_bus.key_down);
    end
  endtask

  task automatic test_bounce();
    int n0;
    n0 = n_strobes;
    for (int i = 0; i < 40; i++) begin
      keys = ((i / 5) % 2 == 0) ? 16'h0008 : 16'h0000;   // r0/c3 = "A"
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL bounce cycle %0d got %b want %b (col|valid|decode|down)", t, obs, exp_vec);
      end
    end
    checks++;
    if (n_strobes !== n0) begin
      errors++;
      $display("FAIL bounce_no_strobe got %0d strobes want 0", n_strobes - n0);
    end
    keys = 16'h0008;
    repeat (90) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL bounce_stable cycle %0d got %b want %b (col|valid|decode|down)", t, obs, exp_vec);
      end
    end
    checks++;
    if (n_strobes - n0 !== 1 || last_code !== 4'hA) begin
      errors++;
      $display("FAIL bounce_count got %0d strobes code %h want 1 code A", n_strobes - n0, last_code);
    end
    keys = 16'h0;
    repeat (80) tick();
  endtask

  task automatic test_two_keys();
    int n0;
    n0   = n_strobes;
    keys = 16'h8001;   // "1" (r0/c0) and "D" (r3/c3)
    repeat (80) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL two_keys cycle %0d got %b want %b (col|valid|decode|down)", t, obs, exp_vec);
      end
    end
    checks++;
    if (n_strobes - n0 !== 1 || last_code !== 4'h1) begin
      errors++;
      $display("FAIL two_keys_first got %0d strobes code %h want 1 code 1", n_strobes - n0, last_code);
    end
    keys = 16'h8000;   // release "1", keep "D"
    n0   = n_strobes;
    repeat (120) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL two_keys_d_held cycle %0d got %b want %b (col|valid|decode|down)", t, obs, exp_vec);
      end
    end
    checks++;
    if (n_strobes !== n0) begin
      errors++;
      $display("FAIL two_keys_no_d got %0d strobes want 0", n_strobes - n0);
    end
    keys = 16'h0;
    repeat (80) tick();
    keys = 16'h8000;
    repeat (80) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL two_keys_fresh_d cycle %0d got %b want %b (col|valid|decode|down)", t, obs, exp_vec);
      end
    end
    checks++;
    if (n_strobes - n0 !== 1 || last_code !== 4'hD) begin
      errors++;
      $display("FAIL two_keys_d_count got %0d strobes code %h want 1 code D", n_strobes - n0, last_code);
    end
    keys = 16'h0;
    repeat (80) tick();
  endtask

  task automatic test_reset_in_confirm();
    int n0;
    int budget;
    keys   = 16'h0004;   // r0/c2 = "3"
    budget = 60;
    while (m_mode != M_CONF && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (m_mode != M_CONF) begin
      errors++;
      $display("FAIL confirm_reach got budget expired want CONFIRM within 60 cycles");
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_values got %b want %b (col|valid|decode|down)", obs, {4'b1110, 6'b0});
    end
    rst = 1'b0;
    n0  = n_strobes;
    repeat (100) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL reset_held cycle %0d got %b want %b (col|valid|decode|down)", t, obs, exp_vec);
      end
    end
    checks++;
    if (n_strobes !== n0) begin
      errors++;
      $display("FAIL reset_held_no_strobe got %0d strobes want 0", n_strobes - n0);
    end
    keys = 16'h0;
    repeat (80) tick();
    keys = 16'h0004;
    repeat (100) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL reset_repress cycle %0d got %b want %b (col|valid|decode|down)", t, obs, exp_vec);
      end
    end
    checks++;
    if (n_strobes - n0 !== 1 || last_code !== 4'h3) begin
      errors++;
      $display("FAIL reset_repress_count got %0d strobes code %h want 1 code 3", n_strobes - n0, last_code);
    end
    keys = 16'h0;
    repeat (80) tick();
  endtask

  task automatic test_hold_zero();
    int n0;
    int prev_t;
    n0     = n_strobes;
    prev_t = -1;
    keys   = 16'h1000;   // r3/c0 = "0"
    repeat (200) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL hold_zero cycle %0d got %b want %b (col|valid|decode|down)", t, obs, exp_vec);
      end
      if (key_bus.key_valid === 1'b1) begin
        checks++;
        if (key_bus.decode !== 4'h0) begin
          errors++;
          $display("FAIL hold_zero_code got %h want 0", key_bus.decode);
        end
`ifdef KEYPAD_REPEAT_EN
        if (prev_t >= 0) begin
          checks++;
          if (t - 1 - prev_t !== 32) begin
            errors++;
            $display("FAIL repeat_spacing got %0d cycles want 32", t - 1 - prev_t);
          end
        end
`endif
        prev_t = t - 1;
      end
    end
    checks++;
`ifdef KEYPAD_REPEAT_EN
    if (n_strobes - n0 < 4) begin
      errors++;
      $display("FAIL repeat_count got %0d strobes want >= 4", n_strobes - n0);
    end
`else
    if (n_strobes - n0 !== 1) begin
      errors++;
      $display("FAIL hold_zero_count got %0d strobes want 1", n_strobes - n0);
    end
`endif
    keys = 16'h0;
    repeat (80) tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 14; it++) begin
      keys = 16'h0;
      keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 1) == 1) keys[$urandom_range(0, 15)] = 1'b1;
      repeat ($urandom_range(20, 100)) begin
        tick();
        checks++;
        if (obs !== exp_vec) begin
          errors++;
          $display("FAIL random_press iter %0d cycle %0d got %b want %b (col|valid|decode|down)", it, t, obs, exp_vec);
        end
      end
      keys = 16'h0;
      repeat ($urandom_range(10, 80)) begin
        tick();
        checks++;
        if (obs !== exp_vec) begin
          errors++;
          $display("FAIL random_release iter %0d cycle %0d got %b want %b (col|valid|decode|down)", it, t, obs, exp_vec);
        end
      end
    end
  endtask

  initial begin
    keys = 16'h0;
    rst  = 1'b1;
    t    = 0;
    test_reset();
    test_single_press();
    test_bounce();
    test_two_keys();
    test_reset_in_confirm();
    test_hold_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
